hop_scheduler: RTL and testbench
================================

HOP_SCHEDULER -- requirements
Module: hop_scheduler

Interface
REQ-001 Parameter DWELL_CYCLES, default 1000, cycles spent on a channel between evaluations (min 1).
REQ-002 Parameter HYST, default 8, jam-level margin required before hopping (0..255).
REQ-003 Parameter ACK_TIMEOUT, default 64, cycles to wait for hop_ack before fault (min 1).
REQ-004 clk  input  1  clock; all state changes on rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 enable  input  1  scheduler run; low parks scheduler in IDLE.
REQ-007 ch_level0..ch_level3  input  8 each  jam level per channel, unsigned, lower is cleaner.
REQ-008 best_ch  input  2  registered safest-channel index from channel analyzer, valid 1 cycle after ch_level changes.
REQ-009 hop_req  output  1  request to radio to retune to hop_ch.
REQ-010 hop_ch  output  2  target channel, stable while hop_req high.
REQ-011 hop_ack  input  1  radio retune complete, sampled only while hop_req high.
REQ-012 clear_fault  input  1  single-cycle clear of fault.
REQ-013 active_channel  output  2  channel currently in use.
REQ-014 hop_count  output  16  successful hops, saturating.
REQ-015 fault  output  1  sticky ack-timeout flag.

Function
REQ-016 FSM states IDLE, SETTLE, EVAL, HOP, DWELL; registered state, registered outputs.
REQ-017 IDLE -> SETTLE when enable=1; otherwise stay.
REQ-018 SETTLE lasts exactly 1 cycle (covers analyzer register latency) -> EVAL.
REQ-019 EVAL lasts 1 cycle: hop condition = best_ch != active_channel AND ch_level[active_channel] > ch_level[best_ch] + HYST, sum in 9 bits, strict compare.
REQ-020 EVAL -> HOP when hop condition true, latching hop_ch <= best_ch; else -> DWELL.
REQ-021 HOP: hop_req=1 every cycle; hop_ch held constant.
REQ-022 hop_ack=1 in HOP: active_channel <= hop_ch, hop_count increments (holds at 0xFFFF), hop_req=0 next cycle, -> DWELL.
REQ-023 ACK_TIMEOUT cycles in HOP without ack: hop_req drops, fault <= 1, active_channel unchanged, -> DWELL.
REQ-024 hop_ack in the same cycle as timeout expiry: ack wins, no fault.
REQ-025 DWELL lasts exactly DWELL_CYCLES cycles, then -> SETTLE.
REQ-026 enable=0 in SETTLE, EVAL or DWELL: -> IDLE next cycle.
REQ-027 enable=0 in HOP: handshake completes (ack or timeout) normally, then -> IDLE instead of DWELL.
REQ-028 clear_fault=1 clears fault; simultaneous timeout set wins.
REQ-029 hop_ack outside HOP is ignored.

Reset
REQ-030 Reset forces state IDLE, active_channel=0, hop_ch=0, hop_req=0, hop_count=0, fault=0, timer=0.
REQ-031 Reset mid-HOP drops hop_req asynchronously with no count update.

Structure
REQ-032 Package hop_pkg holds state enum and default parameter constants.
REQ-033 Sub-module hop_timer: loadable down-counter with expire flag, shared for dwell and ack timeout (one load per state entry).

Verification (DWELL_CYCLES=4, HYST=8, ACK_TIMEOUT=6)
REQ-034 Levels {50,20,60,70}, active 0, best_ch=1, enable -> hop_req in HOP with hop_ch=1; ack after 2 cycles -> active_channel=1, hop_count=1.
REQ-035 Levels {28,20,60,70}, best_ch=1 (margin 8, not >8) -> no hop_req, DWELL 4 cycles, re-EVAL.
REQ-036 Hop condition, never ack -> hop_req high 6 cycles, then fault=1, active_channel=0; clear_fault -> fault=0.
REQ-037 hop_ack on 6th HOP cycle -> hop succeeds, fault stays 0.
REQ-038 enable dropped mid-DWELL -> IDLE next cycle; dropped mid-HOP -> ack accepted, then IDLE.
REQ-039 reset asserted mid-HOP -> hop_req=0 immediately, all outputs at reset values.

Source files
------------

// File: rtl/hop_pkg.sv
// Shared types and default constants for the channel-hopping scheduler.
package hop_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SETTLE,
        S_EVAL,
        S_HOP,
        S_DWELL
    } state_t;

    localparam int unsigned DEF_DWELL_CYCLES = 1000;
    localparam int unsigned DEF_HYST         = 8;
    localparam int unsigned DEF_ACK_TIMEOUT  = 64;
    localparam int unsigned TIMER_W          = 16;

    function automatic logic [7:0] pick_level(input logic [1:0] sel,
                                              input logic [7:0] l0,
                                              input logic [7:0] l1,
                                              input logic [7:0] l2,
                                              input logic [7:0] l3);
        case (sel)
            2'd0:    return l0;
            2'd1:    return l1;
            2'd2:    return l2;
            default: return l3;
        endcase
    endfunction

endpackage

// File: rtl/hop_timer.sv
// Loadable down-counter; expired is high during the last cycle of a loaded
// interval, so a load of N spans exactly N cycles.
module hop_timer #(
    parameter int unsigned W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         load,
    input  logic [W-1:0] load_val,
    output logic         expired
);

    logic [W-1:0] r_count;

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_count <= '0;
        else if (load)
            r_count <= load_val;
        else if (r_count != '0)
            r_count <= r_count - 1'b1;
    end

    assign expired = (r_count == W'(1));

endmodule

// File: rtl/hop_scheduler.sv
// Channel-hop scheduler: periodically evaluates jam levels and hands the radio
// a retune request, with ack timeout, hysteresis and a saturating hop counter.
module hop_scheduler
    import hop_pkg::*;
#(
    parameter int unsigned DWELL_CYCLES = DEF_DWELL_CYCLES,
    parameter int unsigned HYST         = DEF_HYST,
    parameter int unsigned ACK_TIMEOUT  = DEF_ACK_TIMEOUT
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        enable,
    input  logic [7:0]  ch_level0,
    input  logic [7:0]  ch_level1,
    input  logic [7:0]  ch_level2,
    input  logic [7:0]  ch_level3,
    input  logic [1:0]  best_ch,
    output logic        hop_req,
    output logic [1:0]  hop_ch,
    input  logic        hop_ack,
    input  logic        clear_fault,
    output logic [1:0]  active_channel,
    output logic [15:0] hop_count,
    output logic        fault
);

    state_t              r_state;
    state_t              w_state_nx;
    logic                r_hop_req;
    logic [1:0]          r_hop_ch;
    logic [1:0]          r_active;
    logic [15:0]         r_hop_count;
    logic                r_fault;

    logic                w_load;
    logic [TIMER_W-1:0]  w_load_val;
    logic                w_expired;
    logic                w_start_hop;
    logic                w_hop_done;
    logic                w_timeout;
    logic [7:0]          w_lvl_active;
    logic [7:0]          w_lvl_best;
    logic [8:0]          w_best_plus_hyst;
    logic                w_hop_cond;

    assign w_lvl_active     = pick_level(r_active, ch_level0, ch_level1, ch_level2, ch_level3);
    assign w_lvl_best       = pick_level(best_ch, ch_level0, ch_level1, ch_level2, ch_level3);
    assign w_best_plus_hyst = {1'b0, w_lvl_best} + 9'(HYST);
    assign w_hop_cond       = (best_ch != r_active) && ({1'b0, w_lvl_active} > w_best_plus_hyst);

    hop_timer #(.W(TIMER_W)) u_timer (
        .clk      (clk),
        .reset    (reset),
        .load     (w_load),
        .load_val (w_load_val),
        .expired  (w_expired)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset)
            r_state <= S_IDLE;
        else
            r_state <= w_state_nx;
    end

    always_comb begin
        w_state_nx  = r_state;
        w_load      = 1'b0;
        w_load_val  = '0;
        w_start_hop = 1'b0;
        w_hop_done  = 1'b0;
        w_timeout   = 1'b0;
        case (r_state)
            S_IDLE:   if (enable) w_state_nx = S_SETTLE;
            S_SETTLE: w_state_nx = enable ? S_EVAL : S_IDLE;
            S_EVAL: begin
                if (!enable) begin
                    w_state_nx = S_IDLE;
                end else if (w_hop_cond) begin
                    w_state_nx  = S_HOP;
                    w_start_hop = 1'b1;
                    w_load      = 1'b1;
                    w_load_val  = TIMER_W'(ACK_TIMEOUT);
                end else begin
                    w_state_nx = S_DWELL;
                    w_load     = 1'b1;
                    w_load_val = TIMER_W'(DWELL_CYCLES);
                end
            end
            S_HOP: begin
                // Ack is checked first so an ack on the expiry cycle still succeeds.
                if (hop_ack)
                    w_hop_done = 1'b1;
                else if (w_expired)
                    w_timeout = 1'b1;
                if (w_hop_done || w_timeout) begin
                    w_state_nx = enable ? S_DWELL : S_IDLE;
                    w_load     = enable;
                    w_load_val = TIMER_W'(DWELL_CYCLES);
                end
            end
            S_DWELL: begin
                if (!enable)
                    w_state_nx = S_IDLE;
                else if (w_expired)
                    w_state_nx = S_SETTLE;
            end
            default:  w_state_nx = S_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_hop_req   <= 1'b0;
            r_hop_ch    <= '0;
            r_active    <= '0;
            r_hop_count <= '0;
            r_fault     <= 1'b0;
        end else begin
            if (w_start_hop) begin
                r_hop_req <= 1'b1;
                r_hop_ch  <= best_ch;
            end
            if (w_hop_done || w_timeout)
                r_hop_req <= 1'b0;
            if (w_hop_done) begin
                r_active <= r_hop_ch;
                if (r_hop_count != '1)
                    r_hop_count <= r_hop_count + 16'd1;
            end
            if (w_timeout)
                r_fault <= 1'b1;
            else if (clear_fault)
                r_fault <= 1'b0;
        end
    end

    assign hop_req        = r_hop_req;
    assign hop_ch         = r_hop_ch;
    assign active_channel = r_active;
    assign hop_count      = r_hop_count;
    assign fault          = r_fault;

endmodule

// File: tb/tb_hop_scheduler.sv
// Directed-vector bench for hop_scheduler with DWELL_CYCLES=4, HYST=8, ACK_TIMEOUT=6.
module tb_hop_scheduler;

    logic        clk;
    logic        reset;
    logic        enable;
    logic [7:0]  ch_level0, ch_level1, ch_level2, ch_level3;
    logic [1:0]  best_ch;
    logic        hop_req;
    logic [1:0]  hop_ch;
    logic        hop_ack;
    logic        clear_fault;
    logic [1:0]  active_channel;
    logic [15:0] hop_count;
    logic        fault;

    int unsigned n_checks = 0;
    int unsigned n_fail   = 0;

    hop_scheduler #(
        .DWELL_CYCLES (4),
        .HYST         (8),
        .ACK_TIMEOUT  (6)
    ) dut (
        .clk            (clk),
        .reset          (reset),
        .enable         (enable),
        .ch_level0      (ch_level0),
        .ch_level1      (ch_level1),
        .ch_level2      (ch_level2),
        .ch_level3      (ch_level3),
        .best_ch        (best_ch),
        .hop_req        (hop_req),
        .hop_ch         (hop_ch),
        .hop_ack        (hop_ack),
        .clear_fault    (clear_fault),
        .active_channel (active_channel),
        .hop_count      (hop_count),
        .fault          (fault)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_levels(input logic [7:0] l0, input logic [7:0] l1,
                              input logic [7:0] l2, input logic [7:0] l3);
        ch_level0 = l0;
        ch_level1 = l1;
        ch_level2 = l2;
        ch_level3 = l3;
    endtask

    task automatic check_reset_outputs(input string tag);
        check({tag, "_hop_req"}, 32'(hop_req), 0);
        check({tag, "_hop_ch"}, 32'(hop_ch), 0);
        check({tag, "_active"}, 32'(active_channel), 0);
        check({tag, "_count"}, 32'(hop_count), 0);
        check({tag, "_fault"}, 32'(fault), 0);
    endtask

    task automatic do_reset();
        reset       = 1'b1;
        enable      = 1'b0;
        hop_ack     = 1'b0;
        clear_fault = 1'b0;
        tick();
        tick();
        reset = 1'b0;
        check_reset_outputs("rst");
    endtask

    initial begin
        reset       = 1'b1;
        enable      = 1'b0;
        hop_ack     = 1'b0;
        clear_fault = 1'b0;
        best_ch     = 2'd0;
        set_levels(8'd0, 8'd0, 8'd0, 8'd0);
        #3;
        check_reset_outputs("por");
        tick();
        tick();
        reset = 1'b0;

        // Clear hop: 50 > 20+8, ack on the second HOP cycle
        set_levels(8'd50, 8'd20, 8'd60, 8'd70);
        best_ch = 2'd1;
        enable  = 1'b1;
        tick();
        tick();
        check("t1_eval_no_req", 32'(hop_req), 0);
        tick();
        check("t1_hop_req", 32'(hop_req), 1);
        check("t1_hop_ch", 32'(hop_ch), 1);
        check("t1_active_pre", 32'(active_channel), 0);
        tick();
        check("t1_hop_req_c2", 32'(hop_req), 1);
        hop_ack = 1'b1;
        tick();
        hop_ack = 1'b0;
        check("t1_req_drop", 32'(hop_req), 0);
        check("t1_active", 32'(active_channel), 1);
        check("t1_count", 32'(hop_count), 1);

        // Margin exactly HYST: no hop; then 29 > 28 hops after a 4-cycle dwell
        do_reset();
        set_levels(8'd28, 8'd20, 8'd60, 8'd70);
        best_ch = 2'd1;
        enable  = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            check("t2_no_hop", 32'(hop_req), 0);
        end
        ch_level0 = 8'd29;
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t2_dwell_no_req", 32'(hop_req), 0);
        end
        tick();
        check("t2_reeval_hop", 32'(hop_req), 1);
        check("t2_hop_ch", 32'(hop_ch), 1);

        // Never acked: six HOP cycles then fault
        for (int i = 0; i < 5; i++) begin
            tick();
            check("t3_req_held", 32'(hop_req), 1);
        end
        tick();
        check("t3_req_timeout", 32'(hop_req), 0);
        check("t3_fault", 32'(fault), 1);
        check("t3_active_kept", 32'(active_channel), 0);
        check("t3_count_kept", 32'(hop_count), 0);
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("t3_fault_clr", 32'(fault), 0);
        repeat (4) tick();
        check("t3_second_pre", 32'(hop_req), 0);
        tick();
        check("t3_second_hop", 32'(hop_req), 1);
        repeat (5) tick();
        clear_fault = 1'b1;
        tick();
        clear_fault = 1'b0;
        check("t3_set_wins_req", 32'(hop_req), 0);
        check("t3_set_wins", 32'(fault), 1);

        // Ack on the sixth HOP cycle wins over the timeout
        do_reset();
        set_levels(8'd50, 8'd20, 8'd60, 8'd70);
        best_ch = 2'd1;
        enable  = 1'b1;
        repeat (3) tick();
        check("t4_hop_req", 32'(hop_req), 1);
        repeat (5) tick();
        check("t4_req_c6", 32'(hop_req), 1);
        hop_ack = 1'b1;
        tick();
        hop_ack = 1'b0;
        check("t4_req_drop", 32'(hop_req), 0);
        check("t4_active", 32'(active_channel), 1);
        check("t4_count", 32'(hop_count), 1);
        check("t4_no_fault", 32'(fault), 0);
        hop_ack = 1'b1;
        tick();
        hop_ack = 1'b0;
        check("t4_stray_ack_count", 32'(hop_count), 1);
        check("t4_stray_ack_active", 32'(active_channel), 1);

        // enable dropped in DWELL, then in HOP
        do_reset();
        set_levels(8'd28, 8'd20, 8'd60, 8'd70);
        best_ch = 2'd1;
        enable  = 1'b1;
        repeat (4) tick();
        enable = 1'b0;
        tick();
        enable    = 1'b1;
        ch_level0 = 8'd50;
        tick();
        check("t5_settle", 32'(hop_req), 0);
        tick();
        check("t5_eval", 32'(hop_req), 0);
        tick();
        check("t5_hop_after_idle", 32'(hop_req), 1);
        enable = 1'b0;
        tick();
        check("t5_hop_held", 32'(hop_req), 1);
        hop_ack = 1'b1;
        tick();
        hop_ack = 1'b0;
        check("t5_ack_req", 32'(hop_req), 0);
        check("t5_ack_active", 32'(active_channel), 1);
        check("t5_ack_count", 32'(hop_count), 1);
        best_ch   = 2'd2;
        ch_level2 = 8'd0;
        enable    = 1'b1;
        tick();
        tick();
        check("t5_idle_eval", 32'(hop_req), 0);
        tick();
        check("t5_idle_hop", 32'(hop_req), 1);
        check("t5_idle_hop_ch", 32'(hop_ch), 2);

        // Asynchronous reset in the middle of HOP
        #2;
        reset = 1'b1;
        #1;
        check_reset_outputs("t6_async");
        tick();
        reset = 1'b0;

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
